// File: rtl/axi4_lite_arb_pkg.sv
// Shared types and constants for the AXI4-Lite master arbiter and its helpers.
// Response decoding lives here so every arbiter flavour flags errors the same way.
package axi4_lite_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_RESP
  } arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // Equivalent to resp[1]: both SLVERR and DECERR set the upper bit.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first eligible index strictly after last_grant, wrapping.
// Zero latency; no state, so the caller owns last_grant and decides when a grant is taken.
module rr_grant #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         i_eligible,
  input  logic [$clog2(NREQ)-1:0] i_last_grant,
  output logic [$clog2(NREQ)-1:0] o_grant_idx,
  output logic                    o_grant_valid
);

  localparam int IDXW = $clog2(NREQ);

  logic [IDXW-1:0] w_idx;

  always_comb begin
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_idx         = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = IDXW'((int'(i_last_grant) + i) % NREQ);
      if (!o_grant_valid && i_eligible[w_idx]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_master_arbiter.sv
// Serialises NREQ single-beat requesters onto one AXI4-Lite master, round-robin, one outstanding op.
// Latency 3 cycles request-to-ack minimum; requesters hold req until ack, AXI ready stalls the FSM.
module axi4_lite_master_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,

  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ-1:0]          we_i,
  input  logic [NREQ*ADDR_WIDTH-1:0] adr_i,
  input  logic [NREQ*DATA_W-1:0]   dat_i,
  input  logic [NREQ*STRB_W-1:0]   sel_i,
  output logic [NREQ-1:0]          ack_o,
  output logic                     err_o,
  output logic [DATA_W-1:0]        dat_o,
  output logic                     busy_o,

  output logic                     m_awvalid_o,
  input  logic                     m_awready_i,
  output logic [ADDR_WIDTH-1:0]    m_awaddr_o,
  output logic [2:0]               m_awprot_o,
  output logic                     m_wvalid_o,
  input  logic                     m_wready_i,
  output logic [DATA_W-1:0]        m_wdata_o,
  output logic [STRB_W-1:0]        m_wstrb_o,
  input  logic                     m_bvalid_i,
  output logic                     m_bready_o,
  input  logic [1:0]               m_bresp_i,
  output logic                     m_arvalid_o,
  input  logic                     m_arready_i,
  output logic [ADDR_WIDTH-1:0]    m_araddr_o,
  output logic [2:0]               m_arprot_o,
  input  logic                     m_rvalid_i,
  output logic                     m_rready_o,
  input  logic [DATA_W-1:0]        m_rdata_i,
  input  logic [1:0]               m_rresp_i
);

  localparam int IDXW = $clog2(NREQ);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  // The granted index doubles as last_grant: it is only rewritten on the next grant.
  logic [IDXW-1:0]       r_last_grant;
  logic [IDXW-1:0]       w_grant_idx;
  logic                  w_grant_valid;
  logic [NREQ-1:0]       w_eligible;

  logic                  w_win_we;
  logic [ADDR_WIDTH-1:0] w_win_adr;
  logic [DATA_W-1:0]     w_win_dat;
  logic [STRB_W-1:0]     w_win_sel;

  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  w_aw_done_nxt;
  logic                  w_w_done_nxt;
  logic                  w_load;
  logic                  w_ack_set;
  logic                  w_err_nxt;
  logic                  w_rd_cap;

  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_arvalid;
  logic                  r_busy;
  logic [NREQ-1:0]       r_ack;
  logic                  r_err;
  logic [DATA_W-1:0]     r_rdata;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [DATA_W-1:0]     r_wdata;
  logic [STRB_W-1:0]     r_wstrb;

  // A requester being acked this cycle still shows req high; keep it out of the race.
  assign w_eligible = req_i & ~r_ack;

  rr_grant #(
    .NREQ (NREQ)
  ) u_rr_grant (
    .i_eligible    (w_eligible),
    .i_last_grant  (r_last_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  assign w_win_we  = we_i[w_grant_idx];
  assign w_win_adr = adr_i[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_win_dat = dat_i[int'(w_grant_idx)*DATA_W +: DATA_W];
  assign w_win_sel = sel_i[int'(w_grant_idx)*STRB_W +: STRB_W];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_aw_done_nxt = 1'b0;
    w_w_done_nxt  = 1'b0;
    w_load        = 1'b0;
    w_ack_set     = 1'b0;
    w_err_nxt     = r_err;
    w_rd_cap      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_load      = 1'b1;
          w_state_nxt = w_win_we ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        w_aw_done_nxt = r_aw_done | (r_awvalid & m_awready_i);
        w_w_done_nxt  = r_w_done  | (r_wvalid  & m_wready_i);
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_bvalid_i) begin
          w_ack_set   = 1'b1;
          w_err_nxt   = resp_is_err(m_bresp_i);
          w_state_nxt = IDLE;
        end
      end
      RD_ADDR: begin
        if (r_arvalid && m_arready_i) begin
          w_state_nxt = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_rvalid_i) begin
          w_ack_set   = 1'b1;
          w_err_nxt   = resp_is_err(m_rresp_i);
          w_rd_cap    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_last_grant <= IDXW'(NREQ - 1);
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_busy       <= 1'b0;
      r_ack        <= '0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
      r_awaddr     <= '0;
      r_araddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
    end else begin
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
      r_awvalid <= (w_state_nxt == WR_ADDR) && !w_aw_done_nxt;
      r_wvalid  <= (w_state_nxt == WR_ADDR) && !w_w_done_nxt;
      r_arvalid <= (w_state_nxt == RD_ADDR);
      r_busy    <= (w_state_nxt != IDLE);
      r_err     <= w_err_nxt;

      r_ack <= '0;
      if (w_ack_set) begin
        r_ack[r_last_grant] <= 1'b1;
      end

      if (w_rd_cap) begin
        r_rdata <= m_rdata_i;
      end

      // Capture only the channel being used so the idle channel keeps its last address.
      if (w_load) begin
        r_last_grant <= w_grant_idx;
        if (w_win_we) begin
          r_awaddr <= w_win_adr;
          r_wdata  <= w_win_dat;
          r_wstrb  <= w_win_sel;
        end else begin
          r_araddr <= w_win_adr;
        end
      end
    end
  end

  assign ack_o       = r_ack;
  assign err_o       = r_err;
  assign dat_o       = r_rdata;
  assign busy_o      = r_busy;
  assign m_awvalid_o = r_awvalid;
  assign m_awaddr_o  = r_awaddr;
  assign m_wvalid_o  = r_wvalid;
  assign m_wdata_o   = r_wdata;
  assign m_wstrb_o   = r_wstrb;
  assign m_arvalid_o = r_arvalid;
  assign m_araddr_o  = r_araddr;
  assign m_bready_o  = 1'b1;
  assign m_rready_o  = 1'b1;
  assign m_awprot_o  = AXI_PROT_DEFAULT;
  assign m_arprot_o  = AXI_PROT_DEFAULT;

endmodule
